// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that launches one frame at a time into a UART transmitter.
// Define UART_TX_FIFO_OVF_EN to add the sticky OVERFLOW output.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
`ifdef UART_TX_FIFO_OVF_EN
    output logic                  OVERFLOW,
`endif
    input  logic                  Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_accept;
    logic                  launch;

    // Flags decode the occupancy register only, so WR_EN never reaches FULL/EMPTY combinationally.
    assign FULL      = (count == DEPTH_CNT);
    assign EMPTY     = (count == '0);
    assign COUNT     = count;
    assign wr_accept = WR_EN && !FULL;
    assign launch    = (state == IDLE) && !EMPTY && !Busy;

    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, launch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One launch per frame: wait for Busy to rise, then fall, before the next one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        P_DATA     <= mem[rd_ptr];
                        DATA_VALID <= 1'b1;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (Busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!Busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (WR_EN && FULL) begin
            OVERFLOW <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a simple transmitter Busy model.
// Also checks the sticky OVERFLOW output when built with UART_TX_FIFO_OVF_EN.
module tb_uart_tx_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WR_EN;
    logic       Busy;
    logic [7:0] WR_DATA;
    logic       FULL;
    logic       EMPTY;
    logic       DATA_VALID;
    logic [4:0] COUNT;
    logic [7:0] P_DATA;
`ifdef UART_TX_FIFO_OVF_EN
    logic       OVERFLOW;
`endif

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cycle = 0;
    logic [7:0] obs_q[$];
    int         dv_cycle_q[$];
    bit         raise_pending;
    int         busy_left;

    uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_DATA    (WR_DATA),
        .WR_EN      (WR_EN),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .COUNT      (COUNT),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
`ifdef UART_TX_FIFO_OVF_EN
        .OVERFLOW   (OVERFLOW),
`endif
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic wr_en, input logic [7:0] wr_data, input logic busy);
        WR_EN   = wr_en;
        WR_DATA = wr_data;
        Busy    = busy;
        tick();
    endtask

    // Transmitter model: Busy rises one cycle after DATA_VALID and stays high for 10 cycles.
    task automatic tx_cycle();
        tick();
        if (raise_pending) begin
            Busy          = 1'b1;
            busy_left     = 10;
            raise_pending = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) Busy = 1'b0;
        end
        if (DATA_VALID === 1'b1) begin
            raise_pending = 1'b1;
            obs_q.push_back(P_DATA);
            dv_cycle_q.push_back(cycle);
        end
    endtask

    task automatic do_reset();
        WR_EN         = 1'b0;
        WR_DATA       = '0;
        Busy          = 1'b0;
        raise_pending = 1'b0;
        busy_left     = 0;
        obs_q.delete();
        dv_cycle_q.delete();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        int next_byte;
        int dv_count;

        RST = 1'b1;
        WR_EN = 1'b0;
        WR_DATA = '0;
        Busy = 1'b0;

        // Reset state, then a single byte into an empty FIFO.
        do_reset();
        checkOutput("rst_count", COUNT, 0);
        checkOutput("rst_empty", EMPTY, 1);
        checkOutput("rst_full", FULL, 0);
        checkOutput("rst_dv", DATA_VALID, 0);
        checkOutput("rst_pdata", P_DATA, 0);
`ifdef UART_TX_FIFO_OVF_EN
        checkOutput("rst_overflow", OVERFLOW, 0);
`endif
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("t1_count_after_wr", COUNT, 1);
        checkOutput("t1_dv_not_yet", DATA_VALID, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1_dv", DATA_VALID, 1);
        checkOutput("t1_pdata", P_DATA, 8'hA5);
        checkOutput("t1_count_after_launch", COUNT, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1_dv_one_cycle", DATA_VALID, 0);
        checkOutput("t1_pdata_hold", P_DATA, 8'hA5);

        // Asynchronous reset while DATA_VALID is high.
        do_reset();
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1b_dv_before_rst", DATA_VALID, 1);
        RST = 1'b1;
        #1;
        checkOutput("t1b_dv_async_drop", DATA_VALID, 0);
        checkOutput("t1b_pdata_async_clr", P_DATA, 0);

        // Burst of three bytes paced by the transmitter model.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            WR_EN = 1'b1;
            WR_DATA = 8'(i);
            tx_cycle();
        end
        WR_EN = 1'b0;
        for (int i = 0; i < 80 && obs_q.size() < 3; i++) tx_cycle();
        repeat (30) tx_cycle();
        checkOutput("t2_pulses", obs_q.size(), 3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++)
            checkOutput($sformatf("t2_byte%0d", i), obs_q[i], i + 1);
        // Launch edge E, Busy high on edges E+2..E+11, WAIT_DONE->IDLE at E+12, launch at E+13.
        if (dv_cycle_q.size() >= 3) begin
            checkOutput("t2_gap01", dv_cycle_q[1] - dv_cycle_q[0], 13);
            checkOutput("t2_gap12", dv_cycle_q[2] - dv_cycle_q[1], 13);
        end
        checkOutput("t2_empty_end", EMPTY, 1);

        // Fill past full with Busy held, then drain.
        do_reset();
        for (int i = 0; i < 17; i++) begin
`ifdef UART_TX_FIFO_OVF_EN
            if (i == 16) checkOutput("t3_overflow_before", OVERFLOW, 0);
`endif
            applyStimulus(1'b1, 8'(i), 1'b1);
            if (i == 15) begin
                checkOutput("t3_full_after_16", FULL, 1);
                checkOutput("t3_count_16", COUNT, 16);
            end
        end
        WR_EN = 1'b0;
        checkOutput("t3_count_after_17", COUNT, 16);
        checkOutput("t3_full_after_17", FULL, 1);
        checkOutput("t3_no_launch_busy", DATA_VALID, 0);
`ifdef UART_TX_FIFO_OVF_EN
        checkOutput("t3_overflow_set", OVERFLOW, 1);
`endif
        Busy = 1'b0;
        for (int i = 0; i < 600 && obs_q.size() < 16; i++) tx_cycle();
        repeat (30) tx_cycle();
        checkOutput("t3_drain_count", obs_q.size(), 16);
        for (int i = 0; i < 16 && i < obs_q.size(); i++)
            checkOutput($sformatf("t3_byte%0d", i), obs_q[i], i);
        checkOutput("t3_count_end", COUNT, 0);
        checkOutput("t3_empty_end", EMPTY, 1);
`ifdef UART_TX_FIFO_OVF_EN
        checkOutput("t3_overflow_sticky", OVERFLOW, 1);
`endif

        // Simultaneous write and launch at 15 entries, then ordering across the pointer wrap.
        do_reset();
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'(i), 1'b1);
        checkOutput("t4_count15", COUNT, 15);
        WR_EN = 1'b1;
        WR_DATA = 8'd15;
        Busy = 1'b0;
        tx_cycle();
        WR_EN = 1'b0;
        checkOutput("t4_count_wr_and_launch", COUNT, 15);
        checkOutput("t4_dv_same_edge", DATA_VALID, 1);
        checkOutput("t4_first_byte", P_DATA, 8'h00);
        next_byte = 16;
        for (int i = 0; i < 800 && obs_q.size() < 24; i++) begin
            if (next_byte < 24 && FULL === 1'b0) begin
                WR_EN = 1'b1;
                WR_DATA = 8'(next_byte);
                next_byte++;
            end else begin
                WR_EN = 1'b0;
            end
            tx_cycle();
        end
        WR_EN = 1'b0;
        repeat (30) tx_cycle();
        checkOutput("t4_total", obs_q.size(), 24);
        for (int i = 0; i < 24 && i < obs_q.size(); i++)
            checkOutput($sformatf("t4_byte%0d", i), obs_q[i], i);
        checkOutput("t4_count_end", COUNT, 0);

        // Reset mid-frame flushes pending bytes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1'b1;
            WR_DATA = 8'h40 + 8'(i);
            tx_cycle();
        end
        WR_EN = 1'b0;
        checkOutput("t5_launched_one", obs_q.size(), 1);
        checkOutput("t5_count_pre_rst", COUNT, 3);
        checkOutput("t5_pdata_pre_rst", P_DATA, 8'h40);
        RST = 1'b1;
        #1;
        checkOutput("t5_count_rst", COUNT, 0);
        checkOutput("t5_empty_rst", EMPTY, 1);
        checkOutput("t5_dv_rst", DATA_VALID, 0);
        checkOutput("t5_pdata_rst", P_DATA, 0);
        tick();
        Busy = 1'b0;
        raise_pending = 1'b0;
        busy_left = 0;
        obs_q.delete();
        RST = 1'b0;
        repeat (20) tx_cycle();
        checkOutput("t5_no_launch_after_rst", obs_q.size(), 0);
        WR_EN = 1'b1;
        WR_DATA = 8'h5C;
        tx_cycle();
        WR_EN = 1'b0;
        for (int i = 0; i < 10 && obs_q.size() < 1; i++) tx_cycle();
        checkOutput("t5_new_launch", obs_q.size(), 1);
        if (obs_q.size() > 0) checkOutput("t5_new_byte", obs_q[0], 8'h5C);

        // Busy never rises: FSM must stay parked with no further launches.
        do_reset();
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b1, 8'h3D, 1'b0);
        WR_EN = 1'b0;
        checkOutput("t6_dv", DATA_VALID, 1);
        checkOutput("t6_pdata", P_DATA, 8'h3C);
        checkOutput("t6_count", COUNT, 1);
        dv_count = 0;
        repeat (50) begin
            tick();
            if (DATA_VALID !== 1'b0) dv_count++;
        end
        checkOutput("t6_no_relaunch", dv_count, 0);
        checkOutput("t6_count_held", COUNT, 1);
        checkOutput("t6_pdata_held", P_DATA, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
